// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and index width for the step sequencer.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  localparam int IDX_W = 6;
  localparam int LAST_STEP_DEF = 30;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises an active-low key, debounces it and emits a one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, stable_q, stable_d, lvl_q, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    stable_d = stable_q;
    cnt_d = '0;
    press_d = lvl_q & ~stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      stable_q <= 1'b1;
      lvl_q <= 1'b1;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
      stable_q <= stable_d;
      lvl_q <= stable_q;
      cnt_q <= cnt_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: key-controlled run/pause/direction/clear step counter feeding the digit decoder.
module step_sequencer import seq_pkg::*; #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LAST_STEP = LAST_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_run,
  input  logic             key_dir,
  input  logic             key_clr,
  output logic [IDX_W-1:0] num,
  output logic             running,
  output logic             dir_down,
  output logic             wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_STEP);
  logic run_p, dir_p, clr_p, tick, at_end;
  state_e state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic dir_q, dir_d, wrap_q, wrap_d;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (.clk(clk), .rst_n(rst_n), .key_n(key_run), .press(run_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (.clk(clk), .rst_n(rst_n), .key_n(key_dir), .press(dir_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .rst_n(rst_n), .key_n(key_clr), .press(clr_p));
  always_comb begin
    state_d = state_q;
    psc_d = psc_q;
    num_d = num_q;
    wrap_d = 1'b0;
    dir_d = dir_q ^ (dir_p & ~clr_p);
    tick = (state_q == RUN) && (psc_q == PW'(TICK_DIV - 1));
    at_end = dir_q ? (num_q == '0) : (num_q == LAST);
    if (clr_p) begin
      state_d = IDLE;
      psc_d = '0;
      num_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          num_d = '0;
          if (run_p) begin
            state_d = RUN;
            psc_d = '0;
          end
        end
        RUN: begin
          psc_d = tick ? '0 : psc_q + 1'b1;
          if (tick) num_d = at_end ? (dir_q ? LAST : '0) : (dir_q ? num_q - 1'b1 : num_q + 1'b1);
          wrap_d = tick & at_end;
          if (run_p) state_d = PAUSE;
        end
        PAUSE: state_d = run_p ? RUN : PAUSE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      psc_q <= '0;
      num_q <= '0;
      dir_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q <= psc_d;
      num_q <= num_d;
      dir_q <= dir_d;
      wrap_q <= wrap_d;
    end
  end
  assign num = num_q;
  assign running = (state_q == RUN);
  assign dir_down = dir_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed vector table plus hand-timed sequences for the step sequencer.
module tb_step_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_run = 1'b1, key_dir = 1'b1, key_clr = 1'b1;
  logic [5:0] num;
  logic running, dir_down, wrap;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst_n, kr, kd, kc;
    logic [5:0] num;
    logic run, dn, wr;
  } vec_t;
  vec_t vq[$];
  step_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3), .LAST_STEP(30)) dut (
    .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_dir(key_dir), .key_clr(key_clr),
    .num(num), .running(running), .dir_down(dir_down), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string nm, input int en, input int er, input int ed, input int ew);
    chk({nm, ".num"}, int'(num), en);
    chk({nm, ".running"}, int'(running), er);
    chk({nm, ".dir_down"}, int'(dir_down), ed);
    chk({nm, ".wrap"}, int'(wrap), ew);
  endtask
  task automatic wait_num(input int v, input int lim);
    int k = 0;
    do begin
      cyc(1);
      k++;
    end while (int'(num) != v && k < lim);
    chk($sformatf("wait_num_%0d", v), int'(num), v);
  endtask
  initial begin
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0});
    for (int e = 0; e <= 18; e++)
      vq.push_back('{1'b1, (e < 10) ? 1'b0 : 1'b1, 1'b1, 1'b1,
                     (e < 10) ? 6'd0 : 6'((e - 6) / 4), (e >= 6) ? 1'b1 : 1'b0, 1'b0, 1'b0});
    #1;
    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      key_run = vq[i].kr;
      key_dir = vq[i].kd;
      key_clr = vq[i].kc;
      cyc(1);
      chk_all($sformatf("vec%0d", i), vq[i].num, vq[i].run, vq[i].dn, vq[i].wr);
    end
    wait_num(29, 200);
    cyc(3); chk_all("hold29", 29, 1, 0, 0);
    cyc(1); chk_all("up30", 30, 1, 0, 0);
    cyc(4); chk_all("upwrap", 0, 1, 0, 1);
    cyc(1); chk_all("wrapend", 0, 1, 0, 0);
    cyc(3); chk_all("up1", 1, 1, 0, 0);
    key_dir = 1'b0;
    cyc(4); chk_all("dir_pre_tick", 2, 1, 0, 0);
    cyc(2); chk("dir_before", int'(dir_down), 0);
    cyc(1); chk("dir_after", int'(dir_down), 1);
    cyc(1); chk_all("down1", 1, 1, 1, 0);
    key_dir = 1'b1;
    cyc(4); chk_all("down0", 0, 1, 1, 0);
    cyc(4); chk_all("downwrap", 30, 1, 1, 1);
    cyc(1); chk_all("downwrapend", 30, 1, 1, 0);
    key_clr = 1'b0;
    cyc(6); chk("clr_before", int'(running), 1);
    cyc(1); chk_all("clr", 0, 0, 1, 0);
    key_clr = 1'b1;
    cyc(10); chk_all("idle_hold", 0, 0, 1, 0);
    key_run = 1'b0; key_dir = 1'b0;
    cyc(6); chk_all("rundir_before", 0, 0, 1, 0);
    cyc(1); chk_all("rundir_after", 0, 1, 0, 0);
    key_run = 1'b1; key_dir = 1'b1;
    cyc(4); chk_all("first_step", 1, 1, 0, 0);
    wait_num(4, 100);
    key_run = 1'b0;
    cyc(4); chk_all("pre_pause", 5, 1, 0, 0);
    cyc(3); chk_all("paused", 5, 0, 0, 0);
    key_run = 1'b1;
    cyc(40); chk_all("pause_hold", 5, 0, 0, 0);
    key_run = 1'b0;
    cyc(6); chk_all("resume_before", 5, 0, 0, 0);
    cyc(1); chk_all("resume", 5, 1, 0, 0);
    key_run = 1'b1;
    cyc(1); chk_all("resume_step", 6, 1, 0, 0);
    cyc(10);
    for (int i = 0; i < 3; i++) begin
      key_run = 1'b0; cyc(2);
      key_run = 1'b1; cyc(2);
    end
    chk("bounce_ignored", int'(running), 1);
    key_run = 1'b0;
    cyc(6); chk("bounce_before", int'(running), 1);
    cyc(1); chk("bounce_press", int'(running), 0);
    cyc(3);
    key_run = 1'b1;
    cyc(12); chk("bounce_single", int'(running), 0);
    key_run = 1'b0;
    cyc(8);
    key_run = 1'b1;
    wait_num(11, 200);
    key_clr = 1'b0; key_run = 1'b0;
    cyc(4); chk_all("clrrun_12", 12, 1, 0, 0);
    cyc(2); chk_all("clrrun_before", 12, 1, 0, 0);
    cyc(1); chk_all("clrrun", 0, 0, 0, 0);
    key_clr = 1'b1; key_run = 1'b1;
    cyc(10); chk_all("clrrun_idle", 0, 0, 0, 0);
    key_run = 1'b0; key_dir = 1'b0;
    cyc(8);
    key_run = 1'b1; key_dir = 1'b1;
    wait_num(28, 200);
    chk("pre_reset_dir", int'(dir_down), 1);
    rst_n = 1'b0;
    cyc(1); chk_all("reset_mid", 0, 0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10); chk_all("post_reset", 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
